// File: rtl/gftt_box_seq.sv
// gftt_box_seq: per-frame sequencer for one gftt_box instance.
// Arms the box, forwards pixels, appends a zero flush row and tags the output.
module gftt_box_seq #(
    parameter int DW    = 16,
    parameter int WDT_W = 11,
    parameter int HGT_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WDT_W-1:0] wdt_m1,
    input  logic [HGT_W-1:0] hgt_m1,
    input  logic             frame_start,
    input  logic [DW-1:0]    din,
    input  logic             vin,
    output logic             box_start,
    output logic             box_enb,
    output logic [DW-1:0]    box_din,
    output logic             box_vin,
    input  logic [DW-1:0]    box_dout,
    input  logic             box_vout,
    output logic [DW-1:0]    dout,
    output logic             vout,
    output logic [9:0]       out_col,
    output logic [9:0]       out_row,
    output logic             out_last,
    output logic             frame_done,
    output logic             busy,
    output logic [1:0]       err
);

    typedef enum logic [2:0] {IDLE, RUN, FLUSH, DRAIN, DONE} state_t;

    state_t state;
    state_t state_nxt;

    logic [WDT_W-1:0] wdt;
    logic [HGT_W-1:0] hgt;
    logic [WDT_W-1:0] in_col;
    logic [HGT_W-1:0] in_row;
    logic [WDT_W-1:0] fl_cnt;
    logic [WDT_W-1:0] oc;
    logic [HGT_W-1:0] orow;
    logic             first_run;
    logic             out_seen;

    logic start_ok;
    logic take;
    logic at_end;
    logic emit;
    logic emit_last;

    assign busy       = (state != IDLE);
    assign box_enb    = busy;
    assign frame_done = (state == DONE);
    assign start_ok   = (state == IDLE) && frame_start;
    assign take       = (state == RUN) && vin;
    assign at_end     = (in_col == wdt) && (in_row == hgt);
    assign emit       = busy && box_vout;
    assign emit_last  = (oc == wdt) && (orow == hgt);

    always_comb begin
        state_nxt = state;
        box_start = 1'b0;
        unique case (state)
            IDLE:    if (frame_start) state_nxt = RUN;
            RUN: begin
                box_start = first_run;
                if (take && at_end) state_nxt = FLUSH;
            end
            FLUSH:   if (fl_cnt == wdt) state_nxt = DRAIN;
            DRAIN:   if (out_seen) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            box_vin <= 1'b0;
            box_din <= '0;
        end else begin
            state   <= state_nxt;
            box_vin <= take || (state == FLUSH);
            box_din <= take ? din : '0;
        end
    end

    // Input side: frame geometry, input position and flush length.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdt       <= '0;
            hgt       <= '0;
            in_col    <= '0;
            in_row    <= '0;
            fl_cnt    <= '0;
            first_run <= 1'b0;
            err       <= 2'b00;
        end else begin
            if (start_ok) begin
                wdt       <= wdt_m1;
                hgt       <= hgt_m1;
                in_col    <= '0;
                in_row    <= '0;
                fl_cnt    <= '0;
                first_run <= 1'b1;
                err       <= {vin, 1'b0};
            end else begin
                if (frame_start) err[0] <= 1'b1;
                if (vin && state != RUN) err[1] <= 1'b1;
            end
            if (state == RUN) first_run <= 1'b0;
            if (take) begin
                if (in_col == wdt) begin
                    in_col <= '0;
                    in_row <= in_row + 1'b1;
                end else begin
                    in_col <= in_col + 1'b1;
                end
            end
            if (state == FLUSH) fl_cnt <= fl_cnt + 1'b1;
        end
    end

    // Output side: the first centred row the box can produce is row 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout     <= '0;
            vout     <= 1'b0;
            out_col  <= '0;
            out_row  <= '0;
            out_last <= 1'b0;
            oc       <= '0;
            orow     <= '0;
            out_seen <= 1'b0;
        end else begin
            vout <= emit;
            if (start_ok) begin
                oc       <= '0;
                orow     <= 1;
                out_seen <= 1'b0;
            end else if (emit) begin
                dout     <= box_dout;
                out_col  <= 10'(oc);
                out_row  <= 10'(orow);
                out_last <= emit_last;
                if (emit_last) out_seen <= 1'b1;
                if (oc == wdt) begin
                    oc   <= '0;
                    orow <= orow + 1'b1;
                end else begin
                    oc <= oc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gftt_box_seq.sv
// Randomised scoreboard bench for gftt_box_seq with a behavioural 3x3 box
// standing in for gftt_box on the box_* side.
module tb_gftt_box_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] wdt_m1 = '0;
    logic [9:0]  hgt_m1 = '0;
    logic        frame_start = 1'b0;
    logic [15:0] din = '0;
    logic        vin = 1'b0;
    logic        box_start;
    logic        box_enb;
    logic [15:0] box_din;
    logic        box_vin;
    logic [15:0] box_dout = '0;
    logic        box_vout = 1'b0;
    logic [15:0] dout;
    logic        vout;
    logic [9:0]  out_col;
    logic [9:0]  out_row;
    logic        out_last;
    logic        frame_done;
    logic        busy;
    logic [1:0]  err;

    always #5 clk = ~clk;

    gftt_box_seq dut (
        .clk(clk), .rst_n(rst_n), .wdt_m1(wdt_m1), .hgt_m1(hgt_m1),
        .frame_start(frame_start), .din(din), .vin(vin),
        .box_start(box_start), .box_enb(box_enb), .box_din(box_din),
        .box_vin(box_vin), .box_dout(box_dout), .box_vout(box_vout),
        .dout(dout), .vout(vout), .out_col(out_col), .out_row(out_row),
        .out_last(out_last), .frame_done(frame_done), .busy(busy), .err(err)
    );

    typedef struct packed {
        logic [15:0] val;
        logic [9:0]  col;
        logic [9:0]  row;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] pix [0:63][0:63];
    int          cur_w = 4;
    int          cur_h = 3;
    int          cyc = 0;
    int          done_cnt = 0;
    int          exp_done = 0;
    int          exp_total = 0;
    int          rx_cnt = 0;
    int          vin_total = 0;
    int          last_rx_cyc = 0;
    logic [15:0] t1 [12] = '{0, 9, 9, 0, 0, 9, 9, 0, 0, 6, 6, 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Centred 3x3 sum, zero in the edge columns, saturating at 16 bits.
    function automatic logic [15:0] box_ref(input int c, input int r);
        int s;
        s = 0;
        if (c == 0 || c == cur_w - 1) return 16'h0000;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += int'(pix[r+dr][c+dc]);
        return (s > 65535) ? 16'hFFFF : 16'(s);
    endfunction

    always @(posedge clk) cyc++;

    // Box stand-in: receiving input row r releases centred row r-1, 4 cycles later.
    logic        pv [4];
    logic [15:0] pd [4];
    always @(negedge clk) begin
        int r;
        int c;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                pv[i] = 1'b0;
                pd[i] = '0;
            end
            box_vout  = 1'b0;
            box_dout  = '0;
            rx_cnt    = 0;
            vin_total = 0;
        end else begin
            box_vout = pv[3];
            box_dout = pd[3];
            for (int i = 3; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = 1'b0;
            pd[0] = '0;
            if (box_vin) begin
                r = rx_cnt / cur_w;
                c = rx_cnt % cur_w;
                vin_total++;
                if (r <= cur_h + 1) begin
                    check("box_din", box_din, pix[r][c]);
                    if (r == cur_h + 1) check("flush_gap", cyc, last_rx_cyc + 1);
                    if (r >= 2) begin
                        pv[0] = 1'b1;
                        pd[0] = box_ref(c, r - 1);
                    end
                end else begin
                    check("box_vin_extra", r, cur_h + 1);
                end
                last_rx_cyc = cyc;
                rx_cnt++;
            end
            if (box_start) rx_cnt = 0;
        end
    end

    // Monitor: pop one expectation per presented output pixel.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && vout) begin
            if (exp_q.size() == 0) begin
                check("extra_vout", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("dout", dout, e.val);
                check("out_col", out_col, e.col);
                check("out_row", out_row, e.row);
                check("out_last", out_last, e.last);
            end
        end
        if (rst_n && frame_done) begin
            done_cnt++;
            check("done_pending", exp_q.size(), 0);
        end
    end

    task automatic load(input int w_m1, input int h_m1, input int kind, input logic [15:0] cv);
        cur_w = w_m1 + 1;
        cur_h = h_m1;
        for (int r = 0; r <= cur_h + 1; r++)
            for (int c = 0; c < cur_w; c++)
                if (r == cur_h + 1) pix[r][c] = '0;
                else pix[r][c] = kind ? 16'($urandom_range(0, 9000)) : cv;
    endtask

    task automatic push_exp(input bit use_t1);
        exp_t e;
        for (int r = 1; r <= cur_h; r++)
            for (int c = 0; c < cur_w; c++) begin
                e.val  = use_t1 ? t1[(r-1)*4 + c] : box_ref(c, r);
                e.col  = 10'(c);
                e.row  = 10'(r);
                e.last = (c == cur_w - 1) && (r == cur_h);
                exp_q.push_back(e);
            end
    endtask

    task automatic start_frame(input bit with_vin);
        @(negedge clk);
        wdt_m1      = 11'(cur_w - 1);
        hgt_m1      = 10'(cur_h);
        frame_start = 1'b1;
        vin         = with_vin;
        din         = 16'hBEEF;
        @(negedge clk);
        frame_start = 1'b0;
        vin         = 1'b0;
    endtask

    task automatic feed(input int gap, input int fs_at, input int stop_at);
        int n;
        n = (stop_at >= 0) ? stop_at : cur_w * (cur_h + 1);
        for (int idx = 0; idx < n; idx++) begin
            while ($urandom_range(99) < gap) begin
                vin = 1'b0;
                @(negedge clk);
            end
            vin         = 1'b1;
            din         = pix[idx / cur_w][idx % cur_w];
            frame_start = (idx == fs_at);
            @(negedge clk);
        end
        vin         = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic run_frame(input int w_m1, input int h_m1, input int kind,
                             input logic [15:0] cv, input int gap, input int fs_at,
                             input bit use_t1, input bit drain_inj, input bit idle_vin,
                             input logic [1:0] err_exp);
        load(w_m1, h_m1, kind, cv);
        if (idle_vin) begin
            @(negedge clk);
            vin = 1'b1;
            din = 16'h1234;
            @(negedge clk);
            vin = 1'b0;
            @(negedge clk);
            check("err_idle_vin", err[1], 1'b1);
        end
        push_exp(use_t1);
        exp_total += cur_w * (cur_h + 2);
        start_frame(idle_vin);
        feed(gap, fs_at, -1);
        if (drain_inj) begin
            repeat (cur_w + 1) @(negedge clk);
            vin = 1'b1;
            din = 16'h5A5A;
            @(negedge clk);
            vin = 1'b0;
        end
        exp_done++;
        for (int i = 0; i < 50 * cur_w + 200 && done_cnt < exp_done; i++)
            @(negedge clk);
        check("frame_done", done_cnt, exp_done);
        repeat (6) @(negedge clk);
        check("done_count", done_cnt, exp_done);
        check("missing_vout", exp_q.size(), 0);
        check("box_vin_total", vin_total, exp_total);
        check("err", err, err_exp);
        check("busy_end", busy, 1'b0);
        check("box_enb_end", box_enb, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_box_enb", box_enb, 1'b0);
        check("rst_box_start", box_start, 1'b0);
        check("rst_box_vin", box_vin, 1'b0);
        check("rst_vout", vout, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_err", err, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(3, 3, 0, 16'h0001, 0, -1, 1, 0, 0, 2'b00);
        run_frame(3, 3, 0, 16'hFFFF, 0, -1, 0, 0, 0, 2'b00);
        run_frame(39, 19, 1, 16'h0000, 50, -1, 0, 0, 0, 2'b00);
        run_frame(7, 5, 1, 16'h0000, 20, 20, 0, 0, 0, 2'b01);
        run_frame(5, 4, 1, 16'h0000, 0, -1, 0, 1, 1, 2'b10);
        for (int k = 0; k < 3; k++)
            run_frame($urandom_range(2, 15), $urandom_range(2, 10), 1, 16'h0000,
                      $urandom_range(0, 60), -1, 0, 0, 0, 2'b00);

        load(3, 3, 0, 16'h0001);
        push_exp(1);
        start_frame(0);
        feed(0, -1, 2 * cur_w + 1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_total = 0;
        check("abort_busy", busy, 1'b0);
        check("abort_box_enb", box_enb, 1'b0);
        check("abort_vout", vout, 1'b0);
        check("abort_err", err, 2'b00);
        check("abort_no_done", done_cnt, exp_done);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(3, 3, 0, 16'h0001, 0, -1, 1, 0, 0, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
